// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
//   Holds every branch that fetch issued under prediction, oldest first, until
//   execute resolves it. Each resolve compares the stored prediction with the
//   actual outcome and trains the branch lookup table through its write port.
//   A mispredict raises a one-cycle flush with the correct next PC. The queue
//   then spends one RECOVER cycle while fetch redirects.
//
// Ports
//   clk, reset                     clock; asynchronous active-high clear
//   push, push_pc/taken/target     prediction recorded at fetch
//   full, empty, count             occupancy
//   resolve, resolve_pc/taken/target  outcome of the oldest in-flight branch
//   flush, flush_pc                mispredict pulse and redirect PC
//   blt_write, blt_write_key/val, blt_hit  lookup-table training port
//   error                          sticky protocol-violation flag
module branch_resolve_queue #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic                  push_taken,
  input  logic [ADDR_WIDTH-1:0] push_target,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  input  logic                  resolve,
  input  logic [ADDR_WIDTH-1:0] resolve_pc,
  input  logic                  resolve_taken,
  input  logic [ADDR_WIDTH-1:0] resolve_target,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] flush_pc,
  output logic                  blt_write,
  output logic [ADDR_WIDTH-1:0] blt_write_key,
  output logic [ADDR_WIDTH-1:0] blt_write_val,
  output logic                  blt_hit,
  output logic                  error
);

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

  // Entry storage; contents are only meaningful between head and tail, so no reset.
  logic [ADDR_WIDTH-1:0] pc_mem     [DEPTH];
  logic                  taken_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0] target_mem [DEPTH];

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  flush_q, flush_d, blt_write_q, blt_write_d;
  logic                  blt_hit_q, blt_hit_d, error_q, error_d;
  logic [ADDR_WIDTH-1:0] flush_pc_q, flush_pc_d;
  logic [ADDR_WIDTH-1:0] key_q, key_d, val_q, val_d;

  logic in_run, pop, do_write, pc_mismatch, mispredict;
  logic push_err, empty_err, recover_err;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next state: a mispredict in RUN costs exactly one RECOVER cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mispredict) state_d = RECOVER;
      RECOVER: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_run      = (state_q == RUN);
    pop         = in_run && resolve && !empty;
    pc_mismatch = pop && (resolve_pc != pc_mem[head_q]);
    // A PC mismatch means the queue is out of step with execute.
    // Redirect to be safe.
    mispredict  = pop && ((taken_mem[head_q] != resolve_taken) ||
                          (resolve_taken && (target_mem[head_q] != resolve_target)) ||
                          pc_mismatch);
    // A full queue accepts a push only if the same-cycle pop frees a slot.
    // A push in a squashing cycle is wrong-path and is silently discarded.
    do_write    = in_run && push && !mispredict && (!full || pop);
    push_err    = in_run && push && full && !pop;
    empty_err   = in_run && resolve && empty;
    recover_err = (state_q == RECOVER) && resolve;

    head_d  = pop ? head_q + 1'b1 : head_q;
    tail_d  = do_write ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    if (do_write && !pop)      count_d = count_q + 1'b1;
    else if (!do_write && pop) count_d = count_q - 1'b1;
    if (mispredict) begin
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end

    blt_write_d = pop;
    key_d       = pop ? resolve_pc     : key_q;
    val_d       = pop ? resolve_target : val_q;
    blt_hit_d   = pop ? resolve_taken  : blt_hit_q;
    flush_d     = mispredict;
    flush_pc_d  = flush_pc_q;
    if (mispredict) flush_pc_d = resolve_taken ? resolve_target : resolve_pc + 1'b1;
    error_d     = error_q | push_err | empty_err | pc_mismatch | recover_err;
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      pc_mem[tail_q]     <= push_pc;
      taken_mem[tail_q]  <= push_taken;
      target_mem[tail_q] <= push_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      flush_q     <= 1'b0;
      flush_pc_q  <= '0;
      blt_write_q <= 1'b0;
      key_q       <= '0;
      val_q       <= '0;
      blt_hit_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      flush_q     <= flush_d;
      flush_pc_q  <= flush_pc_d;
      blt_write_q <= blt_write_d;
      key_q       <= key_d;
      val_q       <= val_d;
      blt_hit_q   <= blt_hit_d;
      error_q     <= error_d;
    end
  end

  assign flush         = flush_q;
  assign flush_pc      = flush_pc_q;
  assign blt_write     = blt_write_q;
  assign blt_write_key = key_q;
  assign blt_write_val = val_q;
  assign blt_hit       = blt_hit_q;
  assign error         = error_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue.
// Inputs change 1 time unit after a rising edge.
// Outputs are checked 1 time unit after the following edge.
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        push, push_taken, resolve, resolve_taken;
  logic [15:0] push_pc, push_target, resolve_pc, resolve_target;
  logic        full, empty, flush, blt_write, blt_hit, error;
  logic [3:0]  count;
  logic [15:0] flush_pc, blt_write_key, blt_write_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_queue dut (
    .clk(clk), .reset(reset),
    .push(push), .push_pc(push_pc), .push_taken(push_taken), .push_target(push_target),
    .full(full), .empty(empty), .count(count),
    .resolve(resolve), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target),
    .flush(flush), .flush_pc(flush_pc),
    .blt_write(blt_write), .blt_write_key(blt_write_key), .blt_write_val(blt_write_val),
    .blt_hit(blt_hit), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then move to the sampling point after the edge.
  task automatic step(input logic p, input logic [15:0] ppc, input logic pt, input logic [15:0] ptg,
                      input logic r, input logic [15:0] rpc, input logic rt, input logic [15:0] rtg);
    push = p; push_pc = ppc; push_taken = pt; push_target = ptg;
    resolve = r; resolve_pc = rpc; resolve_taken = rt; resolve_target = rtg;
    @(posedge clk);
    #1;
    $display("step push=%0b pc=%h res=%0b rpc=%h -> cnt=%0d flush=%0b fpc=%h bw=%0b key=%h val=%h hit=%0b err=%0b",
             p, ppc, r, rpc, count, flush, flush_pc, blt_write, blt_write_key, blt_write_val, blt_hit, error);
  endtask

  task automatic idle();
    step(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    push = 0; push_pc = 0; push_taken = 0; push_target = 0;
    resolve = 0; resolve_pc = 0; resolve_taken = 0; resolve_target = 0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_flush", flush, 0);
    chk("rst_flush_pc", flush_pc, 0);
    chk("rst_bw", blt_write, 0);
    chk("rst_key", blt_write_key, 0);
    chk("rst_val", blt_write_val, 0);
    chk("rst_hit", blt_hit, 0);
    chk("rst_error", error, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: correct taken prediction
    step(1, 16'h0010, 1, 16'h0040, 0, 16'h0, 0, 16'h0);
    chk("t1_count_push", count, 1);
    step(0, 16'h0, 0, 16'h0, 1, 16'h0010, 1, 16'h0040);
    chk("t1_bw", blt_write, 1);
    chk("t1_key", blt_write_key, 16'h0010);
    chk("t1_val", blt_write_val, 16'h0040);
    chk("t1_hit", blt_hit, 1);
    chk("t1_flush", flush, 0);
    chk("t1_empty", empty, 1);
    idle();
    chk("t1_bw_pulse", blt_write, 0);
    chk("t1_key_hold", blt_write_key, 16'h0010);

    // 2: direction mispredict squashes queue; push during RECOVER ignored
    step(1, 16'h0010, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    step(1, 16'h0020, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    step(1, 16'h0030, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    chk("t2_count3", count, 3);
    step(0, 16'h0, 0, 16'h0, 1, 16'h0010, 1, 16'h0080);
    chk("t2_flush", flush, 1);
    chk("t2_flush_pc", flush_pc, 16'h0080);
    chk("t2_count0", count, 0);
    step(1, 16'h0050, 1, 16'h0060, 0, 16'h0, 0, 16'h0);
    chk("t2_recover_push", count, 0);
    chk("t2_flush_pulse", flush, 0);
    chk("t2_error", error, 0);

    // 3: not-taken correct at 0xFFFF, then wrap of fall-through PC
    step(1, 16'hFFFF, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    chk("t3_count1", count, 1);
    step(0, 16'h0, 0, 16'h0, 1, 16'hFFFF, 0, 16'h0);
    chk("t3_noflush", flush, 0);
    chk("t3_bw", blt_write, 1);
    chk("t3_hit", blt_hit, 0);
    step(1, 16'hFFFF, 1, 16'h1234, 0, 16'h0, 0, 16'h0);
    step(0, 16'h0, 0, 16'h0, 1, 16'hFFFF, 0, 16'h1234);
    chk("t3_flush", flush, 1);
    chk("t3_flush_pc_wrap", flush_pc, 16'h0000);
    chk("t3_val", blt_write_val, 16'h1234);
    idle();
    chk("t3_error", error, 0);

    // 4: fill, overflow, push+resolve when full, drain in order
    for (int i = 0; i < 8; i++) step(1, 16'h0100 + 16'(i), 1, 16'h0200 + 16'(i), 0, 16'h0, 0, 16'h0);
    chk("t4_full", full, 1);
    chk("t4_count8", count, 8);
    step(1, 16'h0999, 1, 16'h0999, 0, 16'h0, 0, 16'h0);
    chk("t4_drop_count", count, 8);
    chk("t4_drop_error", error, 1);
    step(1, 16'h0108, 1, 16'h0208, 1, 16'h0100, 1, 16'h0200);
    chk("t4_pr_count", count, 8);
    chk("t4_pr_key", blt_write_key, 16'h0100);
    chk("t4_pr_flush", flush, 0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 16'h0, 0, 16'h0, 1, 16'h0100 + 16'(i), 1, 16'h0200 + 16'(i));
      chk("t4_drain_flush", flush, 0);
      chk("t4_drain_key", blt_write_key, 32'h0100 + i);
    end
    chk("t4_empty", empty, 1);

    // 5: resolve while empty; PC mismatch
    do_reset();
    chk("t5_rst_error", error, 0);
    step(0, 16'h0, 0, 16'h0, 1, 16'h0010, 0, 16'h0);
    chk("t5_empty_bw", blt_write, 0);
    chk("t5_empty_error", error, 1);
    do_reset();
    step(1, 16'h0010, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    step(0, 16'h0, 0, 16'h0, 1, 16'h0011, 0, 16'h0);
    chk("t5_mm_flush", flush, 1);
    chk("t5_mm_flush_pc", flush_pc, 16'h0012);
    chk("t5_mm_error", error, 1);
    idle();

    // 6: reset between a resolve and its output edge
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 16'h0300 + 16'(i), 0, 16'h0, 0, 16'h0, 0, 16'h0);
    chk("t6_count4", count, 4);
    push = 0; resolve = 1; resolve_pc = 16'h0777; resolve_taken = 1; resolve_target = 16'h0888;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_flush", flush, 0);
    chk("t6_bw", blt_write, 0);
    chk("t6_count", count, 0);
    chk("t6_error", error, 0);
    @(posedge clk);
    #1;
    chk("t6_flush_edge", flush, 0);
    chk("t6_bw_edge", blt_write, 0);
    resolve = 0;
    reset = 1'b0;
    idle();
    chk("t6_after_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
